// File: rtl/my_dispatch_8_way_pkg.sv
// Shared constants, FSM state type and the round-robin channel search
// for the 8-way dispatcher.
package my_dispatch_pkg;

   localparam int NUM_CH = 8;
   localparam int SEL_W  = 3;

   typedef enum logic {
      IDLE,
      HOLD
   } state_t;

   // First enabled channel at or after start, searching upward modulo NUM_CH.
   // Returns start when no channel is enabled; callers never accept a word then.
   function automatic logic [SEL_W-1:0] next_enabled(
      input logic [NUM_CH-1:0] en,
      input logic [SEL_W-1:0]  start
   );
      logic             found;
      logic [SEL_W-1:0] idx;
      next_enabled = start;
      found        = 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         idx = start + SEL_W'(i);
         if (!found && en[idx]) begin
            next_enabled = idx;
            found        = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/my_dispatch_8_way_if.sv
// Upstream/downstream handshake bundle for the 8-way dispatcher.
// master = the environment driving words in; slave = the dispatcher.
interface my_dispatch_8_way_if #(
   parameter int WIDTH = 16
);
   import my_dispatch_pkg::*;

   logic              in_valid;
   logic [WIDTH-1:0]  in_data;
   logic              in_ready;
   logic [NUM_CH-1:0] chan_en;
   logic [NUM_CH-1:0] out_valid;
   logic [WIDTH-1:0]  out_data;
   logic [NUM_CH-1:0] out_ready;
   logic [15:0]       sent_count;

   modport master (
      output in_valid, in_data, chan_en, out_ready,
      input  in_ready, out_valid, out_data, sent_count
   );

   modport slave (
      input  in_valid, in_data, chan_en, out_ready,
      output in_ready, out_valid, out_data, sent_count
   );

endinterface

// File: rtl/my_dispatch_8_way_dmux.sv
// 1-to-8 demultiplexer: drives din onto output bit sel, all others 0.
module my_dmux_8_way
   import my_dispatch_pkg::*;
(
   input  logic              din,
   input  logic [SEL_W-1:0]  sel,
   output logic [NUM_CH-1:0] dout
);

   always_comb begin
      dout      = '0;
      dout[sel] = din;
   end

endmodule

// File: rtl/my_dispatch_8_way.sv
// 1-to-8 round-robin dispatcher with a one-entry holding register;
// sustains one word per cycle when the target channel is ready.
module my_dispatch_8_way
   import my_dispatch_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input logic                clk,
   input logic                rst_n,
   my_dispatch_8_way_if.slave bus
);

   state_t            state;
   logic [SEL_W-1:0]  ptr;
   logic [SEL_W-1:0]  tgt;
   logic [SEL_W-1:0]  start;
   logic [WIDTH-1:0]  data_q;
   logic [15:0]       cnt;
   logic              hold_flag;
   logic              out_hs;
   logic              in_hs;
   logic              any_en;
   logic [NUM_CH-1:0] valid_vec;

   assign hold_flag = (state == HOLD);
   assign any_en    = (bus.chan_en != '0);
   assign out_hs    = hold_flag && bus.out_ready[tgt];
   assign in_hs     = bus.in_valid && bus.in_ready;

   // A word accepted alongside an output handshake searches from the
   // pointer value that handshake is about to produce.
   assign start = out_hs ? (tgt + SEL_W'(1)) : ptr;

   assign bus.in_ready   = any_en && (!hold_flag || out_hs);
   assign bus.out_data   = data_q;
   assign bus.sent_count = cnt;
   assign bus.out_valid  = valid_vec;

   my_dmux_8_way u_dmux (
      .din  (hold_flag),
      .sel  (tgt),
      .dout (valid_vec)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         ptr    <= '0;
         tgt    <= '0;
         data_q <= '0;
         cnt    <= '0;
      end else begin
         if (out_hs) begin
            ptr <= tgt + SEL_W'(1);
            cnt <= cnt + 16'd1;
         end
         case (state)
            IDLE: begin
               if (in_hs) begin
                  state  <= HOLD;
                  data_q <= bus.in_data;
                  tgt    <= next_enabled(bus.chan_en, start);
               end
            end
            HOLD: begin
               if (in_hs) begin
                  data_q <= bus.in_data;
                  tgt    <= next_enabled(bus.chan_en, start);
               end else if (out_hs) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_my_dispatch_8_way.sv
// Directed bench for my_dispatch_8_way: vector table plus hand-written
// sequences for stall, reset-while-holding and counter wrap.
module tb_my_dispatch_8_way;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   my_dispatch_8_way_if #(.WIDTH(16)) bus ();

   my_dispatch_8_way #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        iv;
      logic [15:0] d;
      logic [7:0]  en;
      logic [7:0]  rdy;
      logic        exp_ir;
      logic [7:0]  exp_ov;
      logic [15:0] exp_d;
      logic [15:0] exp_cnt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic iv, logic [15:0] d, logic [7:0] en, logic [7:0] rdy,
                               logic ir, logic [7:0] ov, logic [15:0] ed, logic [15:0] ec);
      vec_t v;
      v.iv = iv; v.d = d; v.en = en; v.rdy = rdy;
      v.exp_ir = ir; v.exp_ov = ov; v.exp_d = ed; v.exp_cnt = ec;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(logic iv, logic [15:0] d, logic [7:0] en, logic [7:0] rdy);
      bus.in_valid  = iv;
      bus.in_data   = d;
      bus.chan_en   = en;
      bus.out_ready = rdy;
   endtask

   task automatic do_reset();
      @(negedge clk);
      drive(1'b0, 16'h0, 8'h00, 8'h00);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic apply(vec_t v, int idx);
      @(negedge clk);
      drive(v.iv, v.d, v.en, v.rdy);
      #1;
      chk($sformatf("vec%0d in_ready", idx), 32'(bus.in_ready), 32'(v.exp_ir));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d out_valid", idx), 32'(bus.out_valid), 32'(v.exp_ov));
      chk($sformatf("vec%0d out_data", idx), 32'(bus.out_data), 32'(v.exp_d));
      chk($sformatf("vec%0d sent_count", idx), 32'(bus.sent_count), 32'(v.exp_cnt));
   endtask

   initial begin
      drive(1'b0, 16'h0, 8'h00, 8'h00);

      // Round-robin over all channels, 10 words back to back
      for (int k = 0; k < 10; k++)
         vecs.push_back(mk(1'b1, 16'(100 + k), 8'hFF, 8'hFF, 1'b1,
                           8'(1 << (k % 8)), 16'(100 + k), 16'(k)));
      vecs.push_back(mk(1'b0, 16'h0, 8'hFF, 8'hFF, 1'b1, 8'h00, 16'd109, 16'd10));
      // Sparse mask: ptr is 2 here, words go to 2,5,7,2
      vecs.push_back(mk(1'b1, 16'd200, 8'hA4, 8'hFF, 1'b1, 8'h04, 16'd200, 16'd10));
      vecs.push_back(mk(1'b1, 16'd201, 8'hA4, 8'hFF, 1'b1, 8'h20, 16'd201, 16'd11));
      vecs.push_back(mk(1'b1, 16'd202, 8'hA4, 8'hFF, 1'b1, 8'h80, 16'd202, 16'd12));
      vecs.push_back(mk(1'b1, 16'd203, 8'hA4, 8'hFF, 1'b1, 8'h04, 16'd203, 16'd13));
      vecs.push_back(mk(1'b0, 16'h0, 8'hA4, 8'hFF, 1'b1, 8'h00, 16'd203, 16'd14));
      // No channel enabled: nothing accepted
      for (int k = 0; k < 3; k++)
         vecs.push_back(mk(1'b1, 16'h1234, 8'h00, 8'hFF, 1'b0, 8'h00, 16'd203, 16'd14));
      vecs.push_back(mk(1'b0, 16'h0, 8'hFF, 8'hFF, 1'b1, 8'h00, 16'd203, 16'd14));

      // Reset state
      #2;
      chk("reset out_valid", 32'(bus.out_valid), 32'h0);
      chk("reset out_data", 32'(bus.out_data), 32'h0);
      chk("reset sent_count", 32'(bus.sent_count), 32'h0);
      chk("reset in_ready", 32'(bus.in_ready), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) apply(vecs[i], i);

      // Stall on channel 0, mask change while held, then release
      do_reset();
      drive(1'b1, 16'h0A0A, 8'hFF, 8'hFE);
      @(posedge clk); #1;
      chk("stall first out_valid", 32'(bus.out_valid), 32'h01);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         drive(1'b1, 16'h0B0B, (k == 2) ? 8'h02 : 8'hFF, 8'hFE);
         #1;
         chk("stall in_ready", 32'(bus.in_ready), 32'h0);
         @(posedge clk); #1;
         chk("stall out_valid", 32'(bus.out_valid), 32'h01);
         chk("stall out_data", 32'(bus.out_data), 32'h0A0A);
      end
      @(negedge clk);
      drive(1'b1, 16'h0B0B, 8'hFF, 8'hFF);
      #1;
      chk("release in_ready", 32'(bus.in_ready), 32'h1);
      @(posedge clk); #1;
      chk("release out_valid", 32'(bus.out_valid), 32'h02);
      chk("release out_data", 32'(bus.out_data), 32'h0B0B);
      chk("release sent_count", 32'(bus.sent_count), 32'h1);

      // Reset while holding BEEF for channel 3
      do_reset();
      drive(1'b1, 16'hBEEF, 8'h08, 8'h00);
      @(posedge clk); #1;
      chk("beef out_valid", 32'(bus.out_valid), 32'h08);
      chk("beef out_data", 32'(bus.out_data), 32'hBEEF);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid-reset out_valid", 32'(bus.out_valid), 32'h0);
      chk("mid-reset sent_count", 32'(bus.sent_count), 32'h0);
      chk("mid-reset out_data", 32'(bus.out_data), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 16'h5555, 8'hFF, 8'hFF);
      @(posedge clk); #1;
      chk("post-reset out_valid", 32'(bus.out_valid), 32'h01);
      chk("post-reset sent_count", 32'(bus.sent_count), 32'h0);

      // sent_count wrap
      do_reset();
      drive(1'b1, 16'h7777, 8'hFF, 8'hFF);
      repeat (65535) @(posedge clk);
      @(negedge clk);
      drive(1'b0, 16'h0, 8'hFF, 8'hFF);
      @(posedge clk); #1;
      chk("count at ffff", 32'(bus.sent_count), 32'hFFFF);
      @(negedge clk);
      drive(1'b1, 16'h8888, 8'hFF, 8'hFF);
      @(negedge clk);
      drive(1'b0, 16'h0, 8'hFF, 8'hFF);
      @(posedge clk); #1;
      chk("count wrap", 32'(bus.sent_count), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/my_dispatch_8_way.md
MY_DISPATCH_8_WAY -- requirements
Module: my_dispatch_8_way

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, the data word width in bits.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port in_valid, input, 1 bit: the upstream word is valid.
REQ-005 The module SHALL have port in_data, input, WIDTH bits: the upstream word.
REQ-006 The module SHALL have port in_ready, output, 1 bit: the block accepts the upstream word this cycle.
REQ-007 The module SHALL have port chan_en, input, 8 bits: per-channel enable mask; bit i enables channel i.
REQ-008 The module SHALL have port out_valid, output, 8 bits: one-hot-or-zero valid per channel.
REQ-009 The module SHALL have port out_data, output, WIDTH bits: the held word, shared by all channels.
REQ-010 The module SHALL have port out_ready, input, 8 bits: per-channel ready.
REQ-011 The module SHALL have port sent_count, output, 16 bits: count of completed output handshakes.

Function
REQ-012 The block SHALL be a 1-to-8 round-robin dispatcher with a one-entry holding register, states IDLE (empty) and HOLD (word held).
REQ-013 An upstream handshake SHALL occur when in_valid and in_ready are both 1 at a rising clk edge.
REQ-014 An output handshake SHALL occur when out_valid[tgt] and out_ready[tgt] are both 1, where tgt is the latched 3-bit target.
REQ-015 in_ready SHALL be 1 when chan_en != 0 and either the state is IDLE or an output handshake occurs this cycle; otherwise 0.
REQ-016 On an upstream handshake the block SHALL latch in_data into out_data and latch tgt as the first enabled channel at or after ptr, searching upward modulo 8.
REQ-017 out_valid SHALL be the steered form of the HOLD flag: bit tgt equals 1 in HOLD, and all bits are 0 in IDLE.
REQ-018 On an output handshake, ptr SHALL become tgt+1 modulo 8 (7 wraps to 0), and sent_count SHALL increment, wrapping from 16'hFFFF to 0.
REQ-019 Output handshake without upstream handshake: HOLD -> IDLE. Upstream handshake in IDLE: IDLE -> HOLD. Both in the same cycle: remain in HOLD with the new word, giving 1 word/cycle throughput.
REQ-020 For a word accepted in the same cycle as an output handshake, the target search SHALL start from the updated ptr (tgt+1).
REQ-021 Once a word is latched, changes to chan_en SHALL NOT alter tgt; the held word waits for out_ready[tgt] indefinitely.
REQ-022 When chan_en == 0, in_ready SHALL be 0 and no word SHALL be accepted; a word already held SHALL still complete normally.
REQ-023 out_data SHALL hold its value while in HOLD, and its value in IDLE is the last word sent.
REQ-024 Latency SHALL be one cycle: a word accepted at edge N is visible on out_valid/out_data after edge N.

Reset
REQ-025 While rst_n is 0, the block SHALL immediately set: state=IDLE, ptr=0, tgt=0, out_valid=0, out_data=0, sent_count=0.
REQ-026 Assertion of reset mid-HOLD SHALL discard the held word without a handshake and without incrementing sent_count.
REQ-027 Reset release SHALL be synchronous to clk; the first handshake is possible at the first rising edge after rst_n goes to 1.

Structure
REQ-028 Package my_dispatch_pkg SHALL hold: NUM_CH=8, SEL_W=3, and the state enum {IDLE, HOLD}.
REQ-029 The block SHALL instantiate exactly one my_dmux_8_way to steer the HOLD flag onto out_valid, with sel=tgt.
REQ-030 The next-enabled-channel search SHALL be a combinational function in the package, returning a 3-bit channel index.

Verification
REQ-031 Scenario: chan_en=8'hFF, out_ready=8'hFF, in_valid held high for 10 words -> words appear on channels 0,1,...,7,0,1, one per cycle; sent_count=10.
REQ-032 Scenario: chan_en=8'b1010_0100 -> successive words go to channels 2, 5, 7, 2.
REQ-033 Scenario: out_ready[0]=0 with the word held on channel 0 for 5 cycles -> out_valid=8'h01 stable, in_ready=0 throughout; raising out_ready[0] completes the handshake, and the next word goes to channel 1.
REQ-034 Scenario: chan_en=0 with in_valid=1 -> in_ready=0 and out_valid=0 for all cycles.
REQ-035 Scenario: rst_n pulsed low while holding 16'hBEEF for channel 3 -> out_valid=0 and sent_count=0 at once; the next word after release goes to channel 0.
REQ-036 Scenario: preload sent_count to 16'hFFFF via 65535 words, then send one more -> sent_count=0.
